// File: rtl/fir_coef_loader_pkg.sv
// Shared constants, FSM state encoding and wrap-lane helper for the FIR coefficient loader.
// The build defaults below apply only when the including flow has not set them.
`ifndef L_LDN
`define L_LDN 5
`endif
`ifndef P_LEN
`define P_LEN 6
`endif
`ifndef FIR_CO_WIDTH
`define FIR_CO_WIDTH 14
`endif

package fir_coef_loader_pkg;

   localparam int L_LDN        = `L_LDN;
   localparam int P_LEN        = `P_LEN;
   localparam int FIR_CO_WIDTH = `FIR_CO_WIDTH;
   localparam int LUT_LEN      = 2**L_LDN + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WRAP = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   // The wrap row is row 0 rotated down by one lane, so tap j lands in lane j-1.
   function automatic int wrap_lane(input int j, input int p_len);
      return (j + p_len - 1) % p_len;
   endfunction

endpackage

// File: rtl/fir_coef_idx_cnt.sv
// Phase/tap index counters: i (phase) advances on every beat, j (tap) advances when i wraps.
module fir_coef_idx_cnt
   import fir_coef_loader_pkg::*;
#(
   parameter int  L_LDN = 5,
   parameter int  P_LEN = 6,
   localparam int J_W   = (P_LEN > 1) ? $clog2(P_LEN) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr,
   input  logic             adv,
   output logic [L_LDN-1:0] i_idx,
   output logic [J_W-1:0]   j_idx,
   output logic             last,
   output logic             i_zero
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         i_idx <= '0;
         j_idx <= '0;
      end else if (adv) begin
         i_idx <= i_idx + 1'b1;
         if (i_idx == '1) begin
            j_idx <= (j_idx == J_W'(P_LEN - 1)) ? '0 : j_idx + 1'b1;
         end
      end
   end

   assign last   = (i_idx == '1) && (j_idx == J_W'(P_LEN - 1));
   assign i_zero = (i_idx == '0);

endmodule

// File: rtl/fir_coef_loader.sv
// Writes a streamed coefficient file into the polyphase coefficient RAM and builds the wrap row.
// Optional checksum of accepted beats is enabled by defining FIR_COEF_CSUM_EN.
module fir_coef_loader
   import fir_coef_loader_pkg::*;
#(
   parameter int  L_LDN   = `L_LDN,
   parameter int  P_LEN   = `P_LEN,
   parameter int  CO_W    = `FIR_CO_WIDTH,
   parameter int  LUT_LEN = 2**L_LDN + 1,
   localparam int J_W     = (P_LEN > 1) ? $clog2(P_LEN) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [CO_W-1:0]       coef_i,
   input  logic                  coef_vld_i,
   output logic                  coef_rdy_o,
   output logic                  wr_en_o,
   output logic [L_LDN:0]        wr_addr_o,
   output logic [P_LEN*CO_W-1:0] wr_data_o,
   output logic [P_LEN-1:0]      wr_lane_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [15:0]           csum_o,
   output logic [1:0]            state_o
);

   localparam logic [P_LEN-1:0] LANE0     = P_LEN'(1);
   localparam logic [L_LDN:0]   WRAP_ADDR = (L_LDN + 1)'(LUT_LEN - 1);

   logic [1:0]       state, state_nxt;
   logic             cnt_clr, cnt_adv, accept;
   logic [L_LDN-1:0] idx_i;
   logic [J_W-1:0]   idx_j;
   logic             idx_last, idx_i_zero;

   fir_coef_idx_cnt #(
      .L_LDN (L_LDN),
      .P_LEN (P_LEN)
   ) u_idx_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr    (cnt_clr),
      .adv    (cnt_adv),
      .i_idx  (idx_i),
      .j_idx  (idx_j),
      .last   (idx_last),
      .i_zero (idx_i_zero)
   );

   // Handshake: a beat transfers on a rising edge where coef_vld_i and coef_rdy_o are
   // both high; coef_rdy_o depends on the state register alone, never on coef_vld_i.
   assign coef_rdy_o = (state == ST_LOAD);
   assign accept     = coef_rdy_o && coef_vld_i;
   assign busy_o     = (state != ST_IDLE);
   assign done_o     = (state == ST_FIN);
   assign state_o    = state;

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_adv   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt = ST_LOAD;
               cnt_clr   = 1'b1;
            end
         end
         ST_LOAD: begin
            if (coef_vld_i) begin
               cnt_adv = 1'b1;
               if (idx_last) begin
                  state_nxt = ST_FIN;
               end else if (idx_i_zero) begin
                  state_nxt = ST_WRAP;
               end
            end
         end
         ST_WRAP: state_nxt = ST_LOAD;
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // In WRAP the counters have only moved i past 0, so idx_j is still the tap of the
   // beat being mirrored and wr_data_o still holds its coefficient.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         wr_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
         wr_lane_o <= '0;
      end else begin
         state   <= state_nxt;
         wr_en_o <= 1'b0;
         if (accept) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= {1'b0, idx_i};
            wr_data_o <= {P_LEN{coef_i}};
            wr_lane_o <= LANE0 << idx_j;
         end else if (state == ST_WRAP) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= WRAP_ADDR;
            wr_lane_o <= LANE0 << wrap_lane(int'(idx_j), P_LEN);
         end
      end
   end

`ifdef FIR_COEF_CSUM_EN
   logic [15:0] csum;

   always_ff @(posedge clk_i) begin
      if (rst_i || (state == ST_IDLE && start_i)) begin
         csum <= '0;
      end else if (accept) begin
         csum <= csum + 16'($signed(coef_i));
      end
   end

   assign csum_o = csum;
`else
   assign csum_o = '0;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomised bench for fir_coef_loader: a negedge monitor rebuilds the RAM image from the
// write port, and each test task compares it against a table derived from the beat list.
module tb_fir_coef_loader;

   localparam int L_LDN   = 5;
   localparam int P_LEN   = 6;
   localparam int CO_W    = 14;
   localparam int ROWS    = 2**L_LDN;
   localparam int LUT_LEN = ROWS + 1;
   localparam int N       = ROWS * P_LEN;
   localparam int N_WR    = N + P_LEN;

   logic                  clk = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  start_i = 1'b0;
   logic [CO_W-1:0]       coef_i = '0;
   logic                  coef_vld_i = 1'b0;
   logic                  coef_rdy_o;
   logic                  wr_en_o;
   logic [L_LDN:0]        wr_addr_o;
   logic [P_LEN*CO_W-1:0] wr_data_o;
   logic [P_LEN-1:0]      wr_lane_o;
   logic                  busy_o;
   logic                  done_o;
   logic [15:0]           csum_o;
   logic [1:0]            state_o;

   always #5 clk = ~clk;

   fir_coef_loader #(
      .L_LDN   (L_LDN),
      .P_LEN   (P_LEN),
      .CO_W    (CO_W),
      .LUT_LEN (LUT_LEN)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .coef_i     (coef_i),
      .coef_vld_i (coef_vld_i),
      .coef_rdy_o (coef_rdy_o),
      .wr_en_o    (wr_en_o),
      .wr_addr_o  (wr_addr_o),
      .wr_data_o  (wr_data_o),
      .wr_lane_o  (wr_lane_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .csum_o     (csum_o),
      .state_o    (state_o)
   );

   int tests_run = 0;
   int tests_failed = 0;

   logic [CO_W-1:0] beats   [N];
   logic [CO_W-1:0] exp_tab [LUT_LEN][P_LEN];
   logic [CO_W-1:0] ram     [LUT_LEN][P_LEN];
   logic [15:0]     exp_q[$];

   int          wr_count = 0;
   int          done_count = 0;
   int          bad_wr = 0;
   logic [15:0] csum_at_done = '0;
   bit          done_wr_ok = 0;
   bit          busy_post_done = 1;
   bit          prev_done = 0;

   // Monitor: replays every RAM write into the image and records done-cycle facts.
   always @(negedge clk) begin
      if (prev_done) busy_post_done = busy_o;
      prev_done = done_o;
      if (wr_en_o) begin
         wr_count++;
         if (int'(wr_addr_o) >= LUT_LEN || $countones(wr_lane_o) != 1 ||
             wr_data_o != {P_LEN{wr_data_o[CO_W-1:0]}}) begin
            bad_wr++;
         end else begin
            for (int l = 0; l < P_LEN; l++)
               if (wr_lane_o[l]) ram[int'(wr_addr_o)][l] = wr_data_o[l*CO_W +: CO_W];
         end
      end
      if (done_o) begin
         done_count++;
         csum_at_done = csum_o;
         done_wr_ok = wr_en_o && (wr_addr_o == 6'd31) && (wr_lane_o == 6'b100000) &&
                      (wr_data_o[CO_W-1:0] == beats[N-1]);
      end
   end

   // Reference: beat k belongs to row k mod ROWS, lane k div ROWS; the wrap row holds
   // row 0 shifted down by one lane with c0 in the top lane.
   task automatic build_expected();
      int s = 0;
      for (int k = 0; k < N; k++) begin
         exp_tab[k % ROWS][k / ROWS] = beats[k];
         s += int'($signed(beats[k]));
      end
      for (int l = 0; l < P_LEN; l++) exp_tab[ROWS][l] = exp_tab[0][(l + 1) % P_LEN];
      exp_q.delete();
`ifdef FIR_COEF_CSUM_EN
      exp_q.push_back(16'(s));
`else
      exp_q.push_back(16'd0);
`endif
   endtask

   task automatic clear_model();
      for (int r = 0; r < LUT_LEN; r++)
         for (int l = 0; l < P_LEN; l++) ram[r][l] = ~exp_tab[r][l];
      wr_count = 0;
      done_count = 0;
      bad_wr = 0;
      csum_at_done = '0;
      done_wr_ok = 0;
      busy_post_done = 1;
   endtask

   function automatic int count_bad_rows();
      int bad = 0;
      for (int r = 0; r < LUT_LEN; r++) begin
         bit row_bad = 0;
         for (int l = 0; l < P_LEN; l++) if (ram[r][l] !== exp_tab[r][l]) row_bad = 1;
         if (row_bad) bad++;
      end
      return bad;
   endfunction

   // Driver: pulses start, then streams beats with gap_pct percent idle cycles.
   // Stops after abort_k accepted beats when abort_k is non-zero.
   task automatic run_load(input int gap_pct, input bit mid_start, input int abort_k,
                           input bit chk_wrap);
      int k = 0;
      int cyc = 0;
      bit vld, will_acc;
      bit wrap_pend = 0;
      bit mid_done = 0;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      while (k < N && cyc < 4 * N) begin
         vld = ($urandom_range(99) >= gap_pct);
         coef_vld_i = vld;
         coef_i = vld ? beats[k] : CO_W'($urandom);
         start_i = 1'b0;
         if (mid_start && !mid_done && k >= 90) begin
            start_i = 1'b1;
            mid_done = 1;
         end
         will_acc = vld && coef_rdy_o;
         @(negedge clk);
         cyc++;
         if (wrap_pend) begin
            wrap_pend = 0;
            tests_run++;
            if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd32 || wr_lane_o !== 6'b000001 ||
                wr_data_o[CO_W-1:0] !== beats[32]) begin
               tests_failed++;
               $display("FAIL wrap_t2: en=%b addr=%0d lane=%b data=%0d, want en=1 addr=32 lane=000001 data=%0d",
                        wr_en_o, wr_addr_o, wr_lane_o, wr_data_o[CO_W-1:0], beats[32]);
            end
         end
         if (will_acc) begin
            if (chk_wrap && k == 32) begin
               tests_run++;
               if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd0 || wr_lane_o !== 6'b000010 ||
                   coef_rdy_o !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL wrap_t1: en=%b addr=%0d lane=%b rdy=%b, want en=1 addr=0 lane=000010 rdy=0",
                           wr_en_o, wr_addr_o, wr_lane_o, coef_rdy_o);
               end
               wrap_pend = 1;
            end
            k++;
            if (k == abort_k) break;
         end
      end
      coef_vld_i = 1'b0;
      start_i = 1'b0;
      tests_run++;
      if (k != N && k != abort_k) begin
         tests_failed++;
         $display("FAIL load_progress: accepted %0d beats in %0d cycles, want %0d", k, cyc, N);
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done_count > 0 && !busy_o) break;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests_run++;
         if ({coef_rdy_o, wr_en_o, wr_addr_o, wr_data_o, wr_lane_o, busy_o, done_o, csum_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b en=%b addr=%0d lane=%b busy=%b done=%b csum=%0d, want all 0",
                     coef_rdy_o, wr_en_o, wr_addr_o, wr_lane_o, busy_o, done_o, csum_o);
         end
      end
      rst_i = 1'b0;
      clear_model();
      coef_vld_i = 1'b1;
      coef_i = CO_W'($urandom);
      repeat (4) @(negedge clk);
      coef_vld_i = 1'b0;
      tests_run++;
      if (coef_rdy_o !== 1'b0 || busy_o !== 1'b0 || wr_count !== 0) begin
         tests_failed++;
         $display("FAIL idle_ignores_vld: rdy=%b busy=%b writes=%0d, want 0 0 0",
                  coef_rdy_o, busy_o, wr_count);
      end
   endtask

   task automatic test_full_load();
      int bad;
      for (int k = 0; k < N; k++) beats[k] = CO_W'(k);
      build_expected();
      clear_model();
      run_load(0, 0, 0, 0);
      wait_idle();
      bad = count_bad_rows();
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL full_table: %0d bad rows, want 0", bad);
      end
      tests_run++;
      if (ram[ROWS][5] !== 14'd0 || ram[ROWS][0] !== 14'd32 || ram[ROWS][4] !== 14'd160) begin
         tests_failed++;
         $display("FAIL wrap_row: lane5=%0d lane0=%0d lane4=%0d, want 0 32 160",
                  ram[ROWS][5], ram[ROWS][0], ram[ROWS][4]);
      end
      tests_run++;
      if (wr_count !== N_WR || bad_wr !== 0) begin
         tests_failed++;
         $display("FAIL full_writes: %0d writes (%0d malformed), want %0d (0)", wr_count, bad_wr, N_WR);
      end
      tests_run++;
      if (done_count !== 1 || !done_wr_ok || busy_post_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_done: pulses=%0d with_last_write=%b busy_after=%b, want 1 1 0",
                  done_count, done_wr_ok, busy_post_done);
      end
      tests_run++;
      if (csum_at_done !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL full_csum: %0d, want %0d", csum_at_done, exp_q[0]);
      end
   endtask

   task automatic test_wrap_timing();
      build_expected();
      clear_model();
      run_load(0, 0, 0, 1);
      wait_idle();
      tests_run++;
      if (busy_o !== 1'b0 || coef_rdy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_end_idle: busy=%b rdy=%b, want 0 0", busy_o, coef_rdy_o);
      end
   endtask

   task automatic test_gaps_mid_start();
      int bad;
      for (int k = 0; k < N; k++) beats[k] = CO_W'(k);
      build_expected();
      clear_model();
      run_load(30, 1, 0, 0);
      wait_idle();
      bad = count_bad_rows();
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL gap_table: %0d bad rows, want 0", bad);
      end
      tests_run++;
      if (wr_count !== N_WR || done_count !== 1) begin
         tests_failed++;
         $display("FAIL gap_counts: writes=%0d done=%0d, want %0d 1", wr_count, done_count, N_WR);
      end
      tests_run++;
      if (csum_at_done !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL gap_csum: %0d, want %0d", csum_at_done, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid_load();
      int bad;
      for (int k = 0; k < N; k++) beats[k] = CO_W'($urandom);
      build_expected();
      clear_model();
      run_load(0, 0, 101, 0);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      tests_run++;
      if ({coef_rdy_o, wr_en_o, wr_addr_o, wr_data_o, wr_lane_o, busy_o, done_o, csum_o} !== '0) begin
         tests_failed++;
         $display("FAIL abort_outputs: rdy=%b en=%b addr=%0d lane=%b busy=%b done=%b csum=%0d, want all 0",
                  coef_rdy_o, wr_en_o, wr_addr_o, wr_lane_o, busy_o, done_o, csum_o);
      end
      tests_run++;
      if (done_count !== 0) begin
         tests_failed++;
         $display("FAIL abort_done: %0d pulses, want 0", done_count);
      end
      for (int k = 0; k < N; k++) beats[k] = CO_W'($urandom);
      build_expected();
      clear_model();
      run_load(10, 0, 0, 0);
      wait_idle();
      bad = count_bad_rows();
      tests_run++;
      if (bad !== 0 || wr_count !== N_WR || done_count !== 1) begin
         tests_failed++;
         $display("FAIL restart_load: bad_rows=%0d writes=%0d done=%0d, want 0 %0d 1",
                  bad, wr_count, done_count, N_WR);
      end
      tests_run++;
      if (csum_at_done !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL restart_csum: %0d, want %0d", csum_at_done, exp_q[0]);
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_wrap_timing();
      test_gaps_mid_start();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
